freq_div_multi: RTL
===================

Name: freq_div_multi

Overview:
- Multi-channel programmable square-wave generator. Next-generation replacement for the single-channel fixed-clock divider.
- Each channel holds a run-time-loadable half-period divisor and produces a 50% duty square wave plus a one-cycle rising-edge tick.
- Divisor updates are glitch-free: they take effect only at a half-period boundary.
- Used for buzzer tones, LED blink rates and game-timing enables.

Parameters:
- NUM_CH, 4, number of independent channels (1..2**CH_W).
- CH_W, 2, width of the channel select.
- DIV_W, 25, width of the divisor and counter. Maximum half-period is 2**DIV_W-1 cycles.
- RST_DIV, 0, divisor loaded into every channel at reset. 0 means the channel is idle.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  divisor write strobe, single cycle.
- wr_ch  in  CH_W  channel addressed by the write.
- wr_div  in  DIV_W  new half-period in clk cycles.
- en  in  NUM_CH  per-channel run enable.
- out  out  NUM_CH  square-wave outputs, registered.
- tick  out  NUM_CH  one-cycle pulse coincident with each 0->1 transition of out.
- pend  out  NUM_CH  a written divisor is waiting for the next boundary.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state changes on posedge clk.
- Reset (rst=1 at a posedge), per channel:
  - div_act=RST_DIV, cnt=0, out=0, tick=0, pend=0.
  - rst overrides wr_en and en in the same cycle.
- Per-channel state: div_act, div_pend, pend, cnt (all DIV_W bits except pend, which is 1 bit).
- Running (en[i]=1, div_act!=0):
  - cnt increments each cycle.
  - Terminal count (TC) is cnt==div_act-1. At TC: cnt<=0 and out<=~out.
  - If pend=1 at TC: div_act<=div_pend and pend<=0.
  - Output period is 2*div_act cycles. div_act=1 toggles out every cycle.
- tick[i]:
  - Asserted for exactly the cycle in which out[i] becomes 1, i.e. registered alongside out.
  - Never asserted while en=0, idle, or in reset.
- Freeze (en[i]=0): cnt and out hold. Writes are still accepted into div_pend/pend. Counting resumes from the held cnt when en returns.
- Idle (div_act==0): cnt=0 and out forced to 0 on the next cycle. A pending divisor is applied on the first cycle after it is written, regardless of en. Counting then starts from cnt=0 with out=0.
- Writes:
  - wr_en=1 with wr_ch<NUM_CH: div_pend<=wr_div and pend<=1 for that channel.
  - wr_ch>=NUM_CH: the write is ignored.
  - Multiple writes before a boundary: the last one wins.
  - Write coincident with TC on the same channel: the new value is loaded straight into div_act at that TC; pend stays 0.
  - Writing 0: at the boundary the channel goes idle and out=0 the following cycle.
- Counter width:
  - cnt is compared with div_act-1 in DIV_W bits; no overflow path is reachable.
  - If div_act shrinks below the current cnt, the situation cannot arise, because changes apply only at TC, when cnt=0.
- Channels are fully independent. Simultaneous TCs on several channels are all serviced in the same cycle.

Optional Feature:
- Macro: FREQ_DIV_IMMEDIATE_LOAD_EN.
- Defined: a write goes directly into div_act with cnt<=0, out unchanged and pend held 0. This gives a fast retune at the cost of one possibly short half-period.
- Not defined: the boundary-synchronous update described above. pend is functional.

Test Plan:
- Reset then write ch0 div=3, en=4'b0001 -> out[0] toggles every 3 cycles (period 6). tick[0] pulses once per 6 cycles. Other outputs stay 0.
- ch1 running div=5; write div=2 at cnt=1 -> pend[1]=1 for 3 cycles, then the next half-periods are 2 cycles. No half-period shorter than 5 occurs before the switch.
- Write on the same cycle as ch2 TC (div 4 -> 7) -> the following half-period is exactly 7 cycles; pend[2] never rises.
- ch3 div=1, en[3] dropped for 10 cycles mid-run -> out[3] and cnt held. On re-enable the toggle pattern continues from the held value. tick[3]=0 while frozen.
- Write div=0 to a running ch0 -> out[0]=0 after the boundary, then stays 0 with no ticks. wr_ch=3 with NUM_CH=3 causes no state change.
- rst asserted mid-run together with wr_en -> next cycle all outputs 0, pend=0, div_act=RST_DIV, and the write is discarded.

Source files
------------

// File: rtl/freq_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : freq_div_multi
// Purpose  : Multi-channel programmable square-wave generator. Each channel
//            holds a run-time loadable half-period divisor and produces a 50%
//            duty square wave plus a one-cycle tick on every rising edge.
//            New divisors are applied only at a half-period boundary, so the
//            output never glitches on a retune.
// Ports    : clk     - system clock
//            rst     - synchronous active-high reset
//            wr_en   - divisor write strobe (single cycle)
//            wr_ch   - channel addressed by the write (>= NUM_CH is ignored)
//            wr_div  - new half-period in clk cycles (0 = idle)
//            en      - per-channel run enable (0 freezes cnt and out)
//            out     - registered square-wave outputs
//            tick    - one-cycle pulse with each 0->1 transition of out
//            pend    - a written divisor waits for the next boundary
// Options  : FREQ_DIV_IMMEDIATE_LOAD_EN - when defined, a write goes straight
//            into the active divisor and restarts the counter (out unchanged,
//            pend always 0); the current half-period may be cut short.
// Revision : 1.0 - initial release
// ============================================================================
module freq_div_multi #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int DIV_W   = 25,
    parameter int RST_DIV = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [DIV_W-1:0] C_RST_DIV = DIV_W'(RST_DIV);
    localparam logic [DIV_W-1:0] C_ONE     = DIV_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] div_act_q, div_act_d;
            logic [DIV_W-1:0] cnt_q, cnt_d;
            logic             out_q, out_d;
            logic             tick_q, tick_d;
            logic             pend_q, pend_d;
            logic             wr_hit;
            logic             idle;
            logic             tc;

            // A channel index always fits below NUM_CH, so an address match
            // implicitly rejects writes to non-existent channels.
            assign wr_hit = wr_en && (wr_ch == CH_W'(gi));
            assign idle   = (div_act_q == '0);
            assign tc     = (cnt_q == div_act_q - C_ONE);

`ifdef FREQ_DIV_IMMEDIATE_LOAD_EN
            always_comb begin
                div_act_d = div_act_q;
                cnt_d     = cnt_q;
                out_d     = out_q;
                tick_d    = 1'b0;
                pend_d    = 1'b0;
                if (wr_hit) begin
                    // Retune now: restart the half-period, keep the level.
                    div_act_d = wr_div;
                    cnt_d     = '0;
                    out_d     = idle ? 1'b0 : out_q;
                end else if (idle) begin
                    cnt_d = '0;
                    out_d = 1'b0;
                end else if (en[gi]) begin
                    if (tc) begin
                        cnt_d  = '0;
                        out_d  = ~out_q;
                        tick_d = ~out_q;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
            end
`else
            logic [DIV_W-1:0] div_pend_q, div_pend_d;

            always_comb begin
                div_act_d  = div_act_q;
                div_pend_d = div_pend_q;
                cnt_d      = cnt_q;
                out_d      = out_q;
                tick_d     = 1'b0;
                pend_d     = pend_q;
                if (idle) begin
                    // An idle channel has no boundary to wait for, so a
                    // pending divisor is taken on the next cycle even when
                    // the channel is disabled.
                    cnt_d = '0;
                    out_d = 1'b0;
                    if (pend_q) begin
                        div_act_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                    if (wr_hit) begin
                        div_pend_d = wr_div;
                        pend_d     = 1'b1;
                    end
                end else if (en[gi] && tc) begin
                    cnt_d  = '0;
                    out_d  = ~out_q;
                    tick_d = ~out_q;
                    // A write landing on the boundary itself bypasses the
                    // pending register; otherwise the pending value applies.
                    if (wr_hit) begin
                        div_act_d = wr_div;
                        pend_d    = 1'b0;
                    end else if (pend_q) begin
                        div_act_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                end else begin
                    if (en[gi]) begin
                        cnt_d = cnt_q + C_ONE;
                    end
                    if (wr_hit) begin
                        div_pend_d = wr_div;
                        pend_d     = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    div_pend_q <= '0;
                end else begin
                    div_pend_q <= div_pend_d;
                end
            end
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    div_act_q <= C_RST_DIV;
                    cnt_q     <= '0;
                    out_q     <= 1'b0;
                    tick_q    <= 1'b0;
                    pend_q    <= 1'b0;
                end else begin
                    div_act_q <= div_act_d;
                    cnt_q     <= cnt_d;
                    out_q     <= out_d;
                    tick_q    <= tick_d;
                    pend_q    <= pend_d;
                end
            end

            assign out[gi]  = out_q;
            assign tick[gi] = tick_q;
            assign pend[gi] = pend_q;
        end
    endgenerate

endmodule
`default_nettype wire
